// File: rtl/hdpldadapt_hip_async_update.sv
// hdpldadapt_hip_async_update: drives unloaded fast/slow SR words onto HIP async outputs, with a polling glitch filter on slow bytes 0-3
module hdpldadapt_hip_async_update #(
  parameter logic SSR_RST_VAL = 1'b1,
  parameter int   CNT_WIDTH   = 4,
  parameter int   STALE_LIMIT = 8
) (
  input  logic        rx_clock_async_rx_osc_clk,
  input  logic        rx_reset_async_rx_osc_clk_rst,
  input  logic [3:0]  r_rx_async_hip_aib_fsr_out_rst_val,
  input  logic [3:0]  r_rx_hip_aib_ssr_out_polling_bypass,
  input  logic        rx_async_hssi_fabric_fsr_load,
  input  logic        rx_async_hssi_fabric_ssr_load,
  input  logic [3:0]  hip_aib_async_fsr_out,
  input  logic [39:0] hip_aib_async_ssr_out,
  output logic [3:0]  hip_aib_fsr_out,
  output logic [39:0] hip_aib_ssr_out,
  output logic        hip_aib_ssr_out_upd,
  output logic [3:0]  hip_aib_ssr_out_stale
);
  localparam logic [CNT_WIDTH-1:0] LIM = CNT_WIDTH'(STALE_LIMIT);
  logic fsr_q, ssr_q, fsr_ev, ssr_ev;
  logic [3:0][7:0] cand;
  logic [3:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [3:0] match;
  logic [39:0] ssr_nxt;
  assign fsr_ev = rx_async_hssi_fabric_fsr_load & ~fsr_q;
  assign ssr_ev = rx_async_hssi_fabric_ssr_load & ~ssr_q;
  // a byte is accepted when bypassed or when it repeats the previous sample
  always_comb begin
    ssr_nxt = hip_aib_ssr_out;
    match   = '0;
    cnt_nxt = cnt;
    for (int b = 0; b < 4; b++) begin
      match[b] = hip_aib_async_ssr_out[8*b +: 8] == cand[b];
      if (ssr_ev && (r_rx_hip_aib_ssr_out_polling_bypass[b] || match[b]))
        ssr_nxt[8*b +: 8] = hip_aib_async_ssr_out[8*b +: 8];
      cnt_nxt[b] = r_rx_hip_aib_ssr_out_polling_bypass[b] ? '0 :
                   !ssr_ev ? cnt[b] :
                   match[b] ? '0 :
                   (cnt[b] == LIM) ? cnt[b] : cnt[b] + CNT_WIDTH'(1);
    end
    if (ssr_ev) ssr_nxt[39:32] = hip_aib_async_ssr_out[39:32];
  end
  always_ff @(posedge rx_clock_async_rx_osc_clk) begin
    if (rx_reset_async_rx_osc_clk_rst) begin
      fsr_q               <= 1'b0;
      ssr_q               <= 1'b0;
      hip_aib_fsr_out     <= r_rx_async_hip_aib_fsr_out_rst_val;
      hip_aib_ssr_out     <= {40{SSR_RST_VAL}};
      hip_aib_ssr_out_upd <= 1'b0;
      cand                <= {32{SSR_RST_VAL}};
      cnt                 <= '0;
    end else begin
      fsr_q               <= rx_async_hssi_fabric_fsr_load;
      ssr_q               <= rx_async_hssi_fabric_ssr_load;
      hip_aib_fsr_out     <= fsr_ev ? hip_aib_async_fsr_out : hip_aib_fsr_out;
      hip_aib_ssr_out     <= ssr_nxt;
      hip_aib_ssr_out_upd <= ssr_nxt != hip_aib_ssr_out;
      cand                <= ssr_ev ? hip_aib_async_ssr_out[31:0] : cand;
      cnt                 <= cnt_nxt;
    end
  end
  always_comb
    for (int b = 0; b < 4; b++) hip_aib_ssr_out_stale[b] = cnt[b] == LIM;
endmodule

// File: tb/tb_hdpldadapt_hip_async_update.sv
// tb_hdpldadapt_hip_async_update: directed and random loads checked against a byte-level behavioural model
module tb_hdpldadapt_hip_async_update;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  rst_val = 4'b1010, bypass = 4'h0;
  logic        fsr_ld = 1'b0, ssr_ld = 1'b0;
  logic [3:0]  fsr_in = '0;
  logic [39:0] ssr_in = '0;
  logic [3:0]  fsr_out, stale;
  logic [39:0] ssr_out;
  logic        upd;
  int passed = 0, total = 0;
  logic [3:0]  m_fsr;
  logic [39:0] m_ssr;
  logic [7:0]  m_cand [4];
  int          m_miss [4];
  logic        m_upd;

  hdpldadapt_hip_async_update dut (
    .rx_clock_async_rx_osc_clk          (clk),
    .rx_reset_async_rx_osc_clk_rst      (rst),
    .r_rx_async_hip_aib_fsr_out_rst_val (rst_val),
    .r_rx_hip_aib_ssr_out_polling_bypass(bypass),
    .rx_async_hssi_fabric_fsr_load      (fsr_ld),
    .rx_async_hssi_fabric_ssr_load      (ssr_ld),
    .hip_aib_async_fsr_out              (fsr_in),
    .hip_aib_async_ssr_out              (ssr_in),
    .hip_aib_fsr_out                    (fsr_out),
    .hip_aib_ssr_out                    (ssr_out),
    .hip_aib_ssr_out_upd                (upd),
    .hip_aib_ssr_out_stale              (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [3:0] es;
    for (int b = 0; b < 4; b++) es[b] = (m_miss[b] == 8);
    chk({tag, ".fsr"}, 64'(fsr_out), 64'(m_fsr));
    chk({tag, ".ssr"}, 64'(ssr_out), 64'(m_ssr));
    chk({tag, ".upd"}, 64'(upd), 64'(m_upd));
    chk({tag, ".stale"}, 64'(stale), 64'(es));
  endtask

  task automatic model_reset();
    m_fsr = rst_val;
    m_ssr = {40{1'b1}};
    m_upd = 1'b0;
    for (int b = 0; b < 4; b++) begin m_cand[b] = 8'hFF; m_miss[b] = 0; end
  endtask

  // a byte reaches the output when bypassed or seen twice in a row
  task automatic model_ssr(input logic [39:0] d);
    logic [39:0] old = m_ssr;
    for (int b = 0; b < 4; b++) begin
      if (bypass[b] || d[8*b +: 8] == m_cand[b]) begin
        m_ssr[8*b +: 8] = d[8*b +: 8];
        m_miss[b] = 0;
      end else if (m_miss[b] < 8) m_miss[b]++;
      m_cand[b] = d[8*b +: 8];
    end
    m_ssr[39:32] = d[39:32];
    m_upd = m_ssr != old;
  endtask

  task automatic set_bypass(input logic [3:0] v);
    @(negedge clk);
    bypass = v;
    for (int b = 0; b < 4; b++) if (v[b]) m_miss[b] = 0;
  endtask

  task automatic ssr_load(input logic [39:0] d, input string tag);
    @(negedge clk);
    ssr_ld = 1'b1;
    ssr_in = d;
    model_ssr(d);
    @(negedge clk);
    ssr_ld = 1'b0;
    ssr_in = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
    check_all(tag);
    m_upd = 1'b0;
    @(negedge clk);
    check_all({tag, ".after"});
  endtask

  task automatic fsr_load(input logic [3:0] d, input int hold, input string tag);
    @(negedge clk);
    fsr_ld = 1'b1;
    fsr_in = d;
    m_fsr = d;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      fsr_in = ~d;
    end
    @(negedge clk);
    fsr_ld = 1'b0;
    fsr_in = 4'($urandom);
    check_all(tag);
  endtask

  function automatic logic [39:0] rnd_word(input logic [39:0] prev);
    logic [39:0] w;
    for (int b = 0; b < 5; b++) begin
      case ($urandom_range(0, 3))
        0: w[8*b +: 8] = prev[8*b +: 8];
        1: w[8*b +: 8] = 8'hFF;
        2: w[8*b +: 8] = 8'h3C;
        default: w[8*b +: 8] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  initial begin
    logic [39:0] w;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.fsr_lit", 64'(fsr_out), 64'h0A);
    chk("reset.ssr_lit", 64'(ssr_out), 64'hFF_FFFF_FFFF);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all("idle");

    fsr_load(4'b0101, 1, "fsr_pulse");
    chk("fsr_pulse_lit", 64'(fsr_out), 64'h5);
    fsr_load(4'b1100, 5, "fsr_hold");
    chk("fsr_hold_lit", 64'(fsr_out), 64'hC);

    set_bypass(4'hF);
    ssr_load(40'h12_3456_789A, "byp_load");
    ssr_load(40'h12_3456_789A, "byp_same");

    set_bypass(4'h0);
    ssr_load(40'hA1_0000_0011, "poll1");
    chk("poll1_byte0", 64'(ssr_out[7:0]), 64'h9A);
    chk("poll1_top", 64'(ssr_out[39:32]), 64'hA1);
    ssr_load(40'hA2_0000_0011, "poll2");
    chk("poll2_byte0", 64'(ssr_out[7:0]), 64'h11);

    for (int i = 0; i < 9; i++) begin
      ssr_load({8'h77, 8'h00, (i % 2 == 0) ? 8'hA5 : 8'h5A, 8'h00, 8'h11}, "alt");
      if (i == 7) chk("stale_8th", 64'(stale), 64'h4);
    end
    chk("stale_sat", 64'(stale), 64'h4);
    chk("alt_hold", 64'(ssr_out[23:16]), 64'h00);
    ssr_load(40'h77_003C_0011, "eq1");
    ssr_load(40'h77_003C_0011, "eq2");
    chk("eq2_byte2", 64'(ssr_out[23:16]), 64'h3C);
    chk("eq2_stale", 64'(stale), 64'h0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) set_bypass(4'($urandom));
      if ($urandom_range(0, 3) == 0) fsr_load(4'($urandom), $urandom_range(1, 3), "rnd_fsr");
      else begin
        w = rnd_word(m_ssr);
        ssr_load(w, "rnd_ssr");
      end
    end

    set_bypass(4'hF);
    @(negedge clk);
    fsr_ld = 1'b1;
    ssr_ld = 1'b1;
    fsr_in = 4'b0110;
    ssr_in = 40'h55_AA55_AA55;
    m_fsr = 4'b0110;
    model_ssr(ssr_in);
    @(negedge clk);
    check_all("simul");
    rst = 1'b1;
    rst_val = 4'b0011;
    @(negedge clk);
    model_reset();
    check_all("mid_reset");
    fsr_in = 4'b1001;
    ssr_in = 40'h01_0203_0405;
    rst = 1'b0;
    @(negedge clk);
    m_fsr = 4'b1001;
    model_ssr(ssr_in);
    check_all("post_reset_ev");
    fsr_ld = 1'b0;
    ssr_ld = 1'b0;
    m_upd = 1'b0;
    @(negedge clk);
    check_all("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL timeout");
  end
endmodule
